// File: rtl/vs_fp_pkg.sv
// rtl/vs_fp_pkg.sv - fixed-point types, saturation limits and MAC scheduler state encoding
package vs_fp_pkg;

  typedef logic signed [31:0] fp_32_t;
  typedef logic signed [63:0] fp_64_t;

  // Symmetric range: the library never produces the most negative 32-bit code.
  localparam fp_32_t FP_INT_MAX = 32'sh7FFF_FFFF;
  localparam fp_32_t FP_INT_MIN = -32'sh7FFF_FFFF;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, RESULT} mac_sched_state_t;

  function automatic fp_32_t fp_sat64(input fp_64_t v);
    if (v > fp_64_t'(FP_INT_MAX)) return FP_INT_MAX;
    if (v < fp_64_t'(FP_INT_MIN)) return FP_INT_MIN;
    return v[31:0];
  endfunction

endpackage

// File: rtl/vs_fp_rr_arbiter.sv
// rtl/vs_fp_rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module vs_fp_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] j;

  // Scan from farthest to nearest so the candidate closest to ptr overwrites the rest.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    j     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDX_W'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/vs_fp_mac_sched.sv
// rtl/vs_fp_mac_sched.sv - round-robin shared fixed-point MAC; VS_FP_MAC_SCHED_ROUND_EN enables round-half-up scaling
module vs_fp_mac_sched
  import vs_fp_pkg::*;
#(
  parameter int Q     = 15,
  parameter int NREQ  = 4,
  parameter int LEN_W = 8,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  output logic [NREQ-1:0]         grant,
  input  logic                    op_valid,
  input  fp_32_t                  op_a,
  input  fp_32_t                  op_b,
  output logic                    op_ready,
  output logic                    res_valid,
  output fp_32_t                  res_data,
  output logic [IDX_W-1:0]        res_id,
  input  logic                    res_ready,
  output logic                    busy
);

`ifdef VS_FP_MAC_SCHED_ROUND_EN
  localparam fp_64_t RND_BIAS = fp_64_t'(64'sd1 <<< (Q - 1));
`else
  localparam fp_64_t RND_BIAS = '0;
`endif

  mac_sched_state_t state, state_nx;

  fp_64_t           acc;
  logic [LEN_W-1:0] count, len_q, len_sel;
  logic [IDX_W-1:0] winner, rr_ptr, res_id_q, arb_idx;
  logic [NREQ-1:0]  grant_q, arb_grant;
  fp_32_t           res_data_q;
  fp_64_t           scaled;
  logic             arb_any, fire, last_beat;

  vs_fp_rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_idx == IDX_W'(i)) len_sel = req_len[i*LEN_W +: LEN_W];
  end

  assign fire      = op_valid && (state == ACCUM);
  assign last_beat = fire && (count == len_q - LEN_W'(1));
  assign scaled    = (acc + RND_BIAS) >>> Q;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arb_any) state_nx = (len_sel == '0) ? RESULT : ACCUM;
      ACCUM:   if (last_beat) state_nx = SCALE;
      SCALE:   state_nx = RESULT;
      RESULT:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant     = grant_q;
    op_ready  = (state == ACCUM);
    res_valid = (state == RESULT);
    res_data  = res_data_q;
    res_id    = res_id_q;
    busy      = (state != IDLE);
  end

  // Accumulator wraps modulo 2^64; saturation happens only when scaling the result.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc        <= '0;
      count      <= '0;
      len_q      <= '0;
      winner     <= '0;
      rr_ptr     <= '0;
      grant_q    <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      case (state)
        IDLE: if (arb_any) begin
          len_q      <= len_sel;
          winner     <= arb_idx;
          grant_q    <= arb_grant;
          acc        <= '0;
          count      <= '0;
          res_data_q <= '0;
          res_id_q   <= arb_idx;
        end
        ACCUM: if (fire) begin
          acc   <= acc + fp_64_t'(op_a) * fp_64_t'(op_b);
          count <= count + LEN_W'(1);
        end
        SCALE: begin
          res_data_q <= fp_sat64(scaled);
          res_id_q   <= winner;
        end
        RESULT: if (res_ready) begin
          grant_q <= '0;
          rr_ptr  <= (winner == IDX_W'(NREQ - 1)) ? '0 : winner + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vs_fp_mac_sched.md
Name: vs_fp_mac_sched

Overview:
- Round-robin scheduler sharing one signed fixed-point multiply-accumulate datapath between NREQ requesters.
- Each granted job streams len operand pairs over a shared operand bus and accumulates full-width products.
- Each job returns one saturated Q-format result tagged with the requester id.
- Sits between vector-producing engines and the fixed-point arithmetic library; replaces per-requester MAC PEs.

Parameters:
Q, 15, fractional bits of fp_32_t operands/result
NREQ, 4, number of requesters (2..16)
LEN_W, 8, width of job length field

Ports:
clock  in  1  clock
reset_n  in  1  synchronous, active-low reset
req_valid  in  NREQ  level job request, one bit per requester
req_len  in  NREQ*LEN_W  packed job lengths; slice i belongs to requester i
grant  out  NREQ  one-hot current owner; 0 when idle
op_valid  in  1  operand pair valid on shared bus (driven by granted requester)
op_a  in  32  fp_32_t operand
op_b  in  32  fp_32_t operand
op_ready  out  1  scheduler accepts operand pair
res_valid  out  1  result valid
res_data  out  32  fp_32_t saturated result
res_id  out  $clog2(NREQ)  index of owning requester
res_ready  in  1  result consumer ready
busy  out  1  state != IDLE

Behaviour:
- Reset:
  - The active-low synchronous reset is reset_n, sampled on clock.
  - On reset: state IDLE; grant=0; op_ready=0; res_valid=0; res_data=0; res_id=0; busy=0; accumulator=0; count=0; rr pointer=0.
  - Reset mid-job aborts the job silently; no result is produced.
- States: IDLE, ACCUM, SCALE, RESULT.
- IDLE:
  - If any req_valid, pick the first set bit at or after the rr pointer (wrapping).
  - Latch len=req_len[winner] and winner id; set grant one-hot next cycle; clear acc/count.
  - len==0 -> RESULT with res_data=0.
  - Otherwise -> ACCUM.
- ACCUM:
  - op_ready=1.
  - Each op_valid&&op_ready: acc <= acc + fp_64_t'(op_a*op_b), full 64-bit signed product; count++.
  - When the beat with count==len-1 fires -> SCALE. op_ready drops in SCALE.
  - op_valid low stalls indefinitely; no timeout.
- SCALE (1 cycle):
  - s = acc >>> Q (arithmetic).
  - Saturate s to [-0x7FFFFFFF, 0x7FFFFFFF] (symmetric, matching library INT_MIN).
  - Register into res_data; res_id=winner -> RESULT.
- RESULT:
  - res_valid=1; res_data/res_id held stable until res_ready.
  - On handshake: grant<=0, rr pointer<=winner+1 (mod NREQ), -> IDLE.
- Latency: grant 1 cycle after req_valid seen in IDLE; res_valid 2 cycles after the last operand beat.
- Accumulator wraps modulo 2^64 (no internal saturation).
- req_valid changes during a job are ignored; the owner must drop req_valid after the result handshake or it is re-queued at lowest priority.
- grant remains asserted from job start through the result handshake.

Optional Feature:
VS_FP_MAC_SCHED_ROUND_EN
- Defined: SCALE adds 2^(Q-1) to acc before the shift (round half up), then saturates.
- Undefined: pure truncation toward -inf via the arithmetic shift.

Decomposition:
- Package vs_fp_pkg:
  - fp_32_t (signed 32), fp_64_t (signed 64).
  - FP_INT_MAX=0x7FFFFFFF, FP_INT_MIN=-0x7FFFFFFF.
  - mac_sched_state_t enum.
- Sub-module vs_fp_rr_arbiter (NREQ): inputs req vector + pointer; outputs one-hot grant, index, any. Purely combinational.

Test Plan:
- Q=15, req0 len=3, each pair a=b=0x00008000 (1.0) -> res_data=0x00018000, res_id=0, grant=0001 throughout.
- req0 and req2 asserted together from reset (ptr 0) -> req0 served first. Keep both asserted -> req2 next, then req0.
- Negative: len=1, a=0xFFFF8000 (-1.0), b=0x00008000 -> 0xFFFF8000.
- Saturation:
  - len=2, a=b=0x7FFF0000 -> 0x7FFFFFFF.
  - a=0x80010000, b=0x7FFF0000 -> 0x80000001.
- Edge cases:
  - len=0 -> res_data=0 and op_ready never asserts.
  - res_ready held low 5 cycles -> res_valid/res_data stable.
  - Reset asserted mid-ACCUM -> IDLE next cycle, no res_valid.
- Rounding: len=1, a=0x00000001, b=0x00004000 -> 0 without the macro, 1 with VS_FP_MAC_SCHED_ROUND_EN.
